bullet_ctrl: RTL and testbench

Sequencer for the player's bullet datapath. It generates the bullet's movement tick and turns the raw fire button into a shoot request with a cooldown. It checks the bullet position against the alien grid after every move and drives the bullet's hit input on a collision. It sits between the input/timing logic, the bullet block, and the alien-grid storage, and reports kills to the score logic.

---
 rtl/bullet_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_bullet_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_ctrl.sv
// Bullet sequencer: movement-tick prescaler, fire-button synchronizer with edge
// detect, and the shot / flight / collision-check FSM with cooldown and shot count.
module bullet_ctrl #(
    parameter int unsigned DIV        = 250000,
    parameter int unsigned COOL_TICKS = 4,
    parameter int unsigned ALIEN_ROWS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_run_i,
    input  logic       fire_btn_i,
    input  logic       bullet_flying_i,
    input  logic [4:0] bullet_x_i,
    input  logic [3:0] bullet_y_i,
    input  logic       alien_present_i,
    output logic       bullet_enable_o,
    output logic       bullet_shoot_o,
    output logic       bullet_hit_o,
    output logic       query_valid_o,
    output logic [4:0] query_x_o,
    output logic [3:0] query_y_o,
    output logic       kill_valid_o,
    output logic [4:0] kill_x_o,
    output logic [3:0] kill_y_o,
    output logic [7:0] shots_fired_o
);

    localparam int unsigned   PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [4:0]    ROW_LIMIT  = 5'(ALIEN_ROWS);
    localparam logic [3:0]    COOL_INIT  = 4'(COOL_TICKS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READY    = 3'd1,
        FIRE     = 3'd2,
        FLIGHT   = 3'd3,
        CHECK    = 3'd4,
        WAIT     = 3'd5,
        HIT      = 3'd6,
        COOLDOWN = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          sync1_q, sync2_q, sync3_q;
    logic [3:0]    cool_q, cool_d;
    logic [7:0]    shots_q, shots_d;
    logic [4:0]    lat_x_q, lat_x_d;
    logic [3:0]    lat_y_q, lat_y_d;
    logic          kill_valid_q, kill_valid_d;
    logic [4:0]    kill_x_q, kill_x_d;
    logic [3:0]    kill_y_q, kill_y_d;

    logic tick_s;
    logic fire_edge_s;
    logic y_in_grid_s;
    logic shoot_s;
    logic hit_s;
    logic query_s;

    assign tick_s      = game_run_i & (presc_q == PRESC_LAST);
    assign fire_edge_s = sync2_q & ~sync3_q;
    assign y_in_grid_s = ({1'b0, bullet_y_i} < ROW_LIMIT);

    // Prescaler: free-runs 0..DIV-1 during play, parked at zero otherwise
    always_comb begin
        presc_d = presc_q;
        if (!game_run_i || tick_s) begin
            presc_d = PRESC_ZERO;
        end else begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; leaving play overrides every other transition
    always_comb begin
        state_d = state_q;
        if (!game_run_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     state_d = READY;
                READY:    if (fire_edge_s) state_d = FIRE; else state_d = READY;
                FIRE:     if (bullet_flying_i) state_d = FLIGHT; else state_d = FIRE;
                FLIGHT: begin
                    if (!bullet_flying_i) begin
                        state_d = COOLDOWN;
                    end else if (tick_s) begin
                        state_d = CHECK;
                    end else begin
                        state_d = FLIGHT;
                    end
                end
                CHECK: begin
                    if (!bullet_flying_i) begin
                        state_d = COOLDOWN;
                    end else if (!y_in_grid_s) begin
                        state_d = FLIGHT;
                    end else begin
                        state_d = WAIT;
                    end
                end
                WAIT:     if (alien_present_i) state_d = HIT; else state_d = FLIGHT;
                HIT:      if (!bullet_flying_i) state_d = COOLDOWN; else state_d = HIT;
                COOLDOWN: if (cool_q == 4'd0) state_d = READY; else state_d = COOLDOWN;
                default:  state_d = IDLE;
            endcase
        end
    end

    // FSM outputs; the grid query is issued only for a live bullet inside the grid
    always_comb begin
        shoot_s = 1'b0;
        hit_s   = 1'b0;
        query_s = 1'b0;
        case (state_q)
            FIRE:    shoot_s = 1'b1;
            HIT:     hit_s   = 1'b1;
            CHECK:   query_s = bullet_flying_i & y_in_grid_s;
            default: query_s = 1'b0;
        endcase
    end

    // Cooldown, shot counter, query latch and kill report next-state
    always_comb begin
        cool_d       = cool_q;
        shots_d      = shots_q;
        lat_x_d      = lat_x_q;
        lat_y_d      = lat_y_q;
        kill_valid_d = 1'b0;
        kill_x_d     = kill_x_q;
        kill_y_d     = kill_y_q;
        if (!game_run_i) begin
            cool_d   = 4'd0;
            kill_x_d = 5'd0;
            kill_y_d = 4'd0;
        end else begin
            if ((state_d == COOLDOWN) && (state_q != COOLDOWN)) begin
                cool_d = COOL_INIT;
            end else if ((state_q == COOLDOWN) && tick_s && (cool_q != 4'd0)) begin
                cool_d = cool_q - 4'd1;
            end else begin
                cool_d = cool_q;
            end
            if ((state_q == FIRE) && bullet_flying_i && (shots_q != 8'hFF)) begin
                shots_d = shots_q + 8'd1;
            end else begin
                shots_d = shots_q;
            end
            if (query_s) begin
                lat_x_d = bullet_x_i;
                lat_y_d = bullet_y_i;
            end else begin
                lat_x_d = lat_x_q;
                lat_y_d = lat_y_q;
            end
            if ((state_q == WAIT) && alien_present_i) begin
                kill_valid_d = 1'b1;
                kill_x_d     = lat_x_q;
                kill_y_d     = lat_y_q;
            end else begin
                kill_valid_d = 1'b0;
            end
        end
    end

    // Datapath registers and the fire-button synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= PRESC_ZERO;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            cool_q       <= 4'd0;
            shots_q      <= 8'd0;
            lat_x_q      <= 5'd0;
            lat_y_q      <= 4'd0;
            kill_valid_q <= 1'b0;
            kill_x_q     <= 5'd0;
            kill_y_q     <= 4'd0;
        end else begin
            presc_q      <= presc_d;
            sync1_q      <= fire_btn_i;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            cool_q       <= cool_d;
            shots_q      <= shots_d;
            lat_x_q      <= lat_x_d;
            lat_y_q      <= lat_y_d;
            kill_valid_q <= kill_valid_d;
            kill_x_q     <= kill_x_d;
            kill_y_q     <= kill_y_d;
        end
    end

    assign bullet_enable_o = tick_s;
    assign bullet_shoot_o  = shoot_s;
    assign bullet_hit_o    = hit_s;
    assign query_valid_o   = query_s;
    assign query_x_o       = query_s ? bullet_x_i : 5'd0;
    assign query_y_o       = query_s ? bullet_y_i : 4'd0;
    assign kill_valid_o    = kill_valid_q;
    assign kill_x_o        = kill_x_q;
    assign kill_y_o        = kill_y_q;
    assign shots_fired_o   = shots_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Directed bench for bullet_ctrl with a behavioural bullet block and a
// one-alien grid model driven cycle by cycle from the stimulus tasks.
module tb_bullet_ctrl;

    localparam int DIV  = 8;
    localparam int COOL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_run = 1'b0;
    logic       fire_btn = 1'b0;
    logic       bullet_flying = 1'b0;
    logic [4:0] bullet_x = 5'd0;
    logic [3:0] bullet_y = 4'd0;
    logic       alien_present = 1'b0;

    logic       bullet_enable_o, bullet_shoot_o, bullet_hit_o, query_valid_o, kill_valid_o;
    logic [4:0] query_x_o, kill_x_o;
    logic [3:0] query_y_o, kill_y_o;
    logic [7:0] shots_fired_o;

    bullet_ctrl #(.DIV(DIV), .COOL_TICKS(COOL), .ALIEN_ROWS(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .game_run_i      (game_run),
        .fire_btn_i      (fire_btn),
        .bullet_flying_i (bullet_flying),
        .bullet_x_i      (bullet_x),
        .bullet_y_i      (bullet_y),
        .alien_present_i (alien_present),
        .bullet_enable_o (bullet_enable_o),
        .bullet_shoot_o  (bullet_shoot_o),
        .bullet_hit_o    (bullet_hit_o),
        .query_valid_o   (query_valid_o),
        .query_x_o       (query_x_o),
        .query_y_o       (query_y_o),
        .kill_valid_o    (kill_valid_o),
        .kill_x_o        (kill_x_o),
        .kill_y_o        (kill_y_o),
        .shots_fired_o   (shots_fired_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic       s_en, s_shoot, s_hit, s_qv, s_kv;
    logic [4:0] s_qx, s_kx, last_qx;
    logic [3:0] s_qy, s_ky, last_qy;
    logic [7:0] s_shots;

    logic [4:0] posh = 5'd0;
    logic       short_flight = 1'b0;
    logic       aon = 1'b0;
    logic [4:0] ax = 5'd5;
    logic [3:0] ay = 4'd6;

    int         n_q = 0, n_kill = 0, n_tick = 0, bad_q = 0, viol_zero = 0, viol_both = 0;
    logic [7:0] qrow_mask = 8'd0;

    // One clock: sample outputs mid-cycle, then advance the bullet and grid models past the edge
    task automatic cyc();
        logic       nf, nap;
        logic [3:0] ny;
        logic [4:0] nx;
        @(negedge clk);
        s_en = bullet_enable_o; s_shoot = bullet_shoot_o; s_hit = bullet_hit_o;
        s_qv = query_valid_o;   s_qx = query_x_o;         s_qy = query_y_o;
        s_kv = kill_valid_o;    s_kx = kill_x_o;          s_ky = kill_y_o;
        s_shots = shots_fired_o;
        if (s_en) n_tick++;
        if (s_qv) begin
            n_q++;
            last_qx = s_qx;
            last_qy = s_qy;
            if (s_qy < 4'd8) qrow_mask[s_qy[2:0]] = 1'b1;
            if (s_qx !== bullet_x || s_qy !== bullet_y) bad_q++;
        end else if (s_qx !== 5'd0 || s_qy !== 4'd0) begin
            viol_zero++;
        end
        if (s_kv) n_kill++;
        if (s_shoot && s_hit) viol_both++;
        nf = bullet_flying; ny = bullet_y; nx = bullet_x;
        if (s_en) begin
            if (!bullet_flying) begin
                if (s_shoot) begin nf = 1'b1; ny = 4'd13; nx = posh; end
            end else if (s_hit || short_flight || bullet_y == 4'd0) begin
                nf = 1'b0;
            end else begin
                ny = bullet_y - 4'd1;
            end
        end
        nap = s_qv && aon && (s_qx == ax) && (s_qy == ay);
        if (s_kv && s_kx == ax && s_ky == ay) aon = 1'b0;
        @(posedge clk);
        #1;
        bullet_flying = nf; bullet_y = ny; bullet_x = nx; alien_present = nap;
    endtask

    task automatic test_reset();
        logic [30:0] all_out;
        rst_n = 1'b0; game_run = 1'b0;
        repeat (3) cyc();
        all_out = {s_en, s_shoot, s_hit, s_qv, s_qx, s_qy, s_kv, s_kx, s_ky, s_shots};
        n_cmp++;
        if (all_out !== 31'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rst_n = 1'b1; game_run = 1'b1;
        cyc();
    endtask

    task automatic test_launch();
        int n, tick_i, fall_i;
        logic got;
        posh = 5'd9; fire_btn = 1'b1; n = 0; got = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (!got) begin cyc(); if (s_shoot) begin got = 1'b1; n = i; end end
        end
        fire_btn = 1'b0;
        n_cmp++;
        if (n !== 4) begin n_err++; $display("FAIL launch_latency: got %0d cycles want 4", n); end
        tick_i = (s_en && s_shoot) ? 0 : -1;
        fall_i = -1;
        for (int i = 1; i <= 30; i++) begin
            if (fall_i < 0) begin
                cyc();
                if (s_en && s_shoot) tick_i = i;
                if (!s_shoot) fall_i = i;
            end
        end
        n_cmp++;
        if (tick_i < 0 || fall_i - tick_i != 2) begin
            n_err++; $display("FAIL shoot_hold: tick at %0d shoot fell at %0d want fall 2 after tick", tick_i, fall_i);
        end
        n_cmp++;
        if (s_shots !== 8'd1) begin n_err++; $display("FAIL shots_after_launch: got %0d want 1", s_shots); end
        n_cmp++;
        if (bullet_flying !== 1'b1 || bullet_y !== 4'd13 || bullet_x !== 5'd9) begin
            n_err++; $display("FAIL launch_bullet: got f=%0d y=%0d x=%0d want 1/13/9", bullet_flying, bullet_y, bullet_x);
        end
    endtask

    task automatic test_miss_top();
        n_q = 0; n_kill = 0; n_tick = 0; bad_q = 0; qrow_mask = 8'd0;
        for (int i = 0; i < 400; i++) begin
            if (bullet_flying) cyc();
        end
        n_cmp++;
        if (n_tick !== 14) begin n_err++; $display("FAIL miss_ticks: got %0d want 14", n_tick); end
        n_cmp++;
        if (n_q !== 8 || qrow_mask !== 8'hFF) begin
            n_err++; $display("FAIL miss_queries: got %0d rows %h want 8 rows ff", n_q, qrow_mask);
        end
        n_cmp++;
        if (bad_q !== 0 || n_kill !== 0) begin
            n_err++; $display("FAIL miss_clean: got badq=%0d kills=%0d want 0/0", bad_q, n_kill);
        end
    endtask

    task automatic test_cooldown();
        logic saw, got;
        int n;
        saw = 1'b0; n_tick = 0; fire_btn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (n_tick < 3) begin cyc(); saw |= s_shoot; if (i == 4) fire_btn = 1'b0; end
        end
        fire_btn = 1'b1;
        repeat (4) begin cyc(); saw |= s_shoot; end
        fire_btn = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_tick < 4) begin cyc(); saw |= s_shoot; end
        end
        n_cmp++;
        if (n_tick !== 4 || saw !== 1'b0) begin
            n_err++; $display("FAIL cooldown_ignore: got ticks=%0d shoot_seen=%0d want 4/0", n_tick, saw);
        end
        posh = 5'd5; aon = 1'b1; fire_btn = 1'b1; got = 1'b0; n = 0;
        for (int i = 1; i <= 10; i++) begin
            if (!got) begin cyc(); if (s_shoot) begin got = 1'b1; n = i; end end
        end
        fire_btn = 1'b0;
        n_cmp++;
        if (n !== 4) begin n_err++; $display("FAIL cooldown_ready: got %0d cycles to shoot want 4", n); end
    endtask

    task automatic test_hit();
        logic got, h0, h1, h2;
        n_q = 0; n_kill = 0; got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!got) begin cyc(); if (s_kv) got = 1'b1; end
        end
        n_cmp++;
        if (!got || s_kx !== 5'd5 || s_ky !== 4'd6 || s_hit !== 1'b1) begin
            n_err++; $display("FAIL hit_kill: got kv=%0d kill=(%0d,%0d) hit=%0d want 1 (5,6) 1", got, s_kx, s_ky, s_hit);
        end
        n_cmp++;
        if (n_q !== 2 || last_qx !== 5'd5 || last_qy !== 4'd6) begin
            n_err++; $display("FAIL hit_query: got n=%0d last=(%0d,%0d) want 2 (5,6)", n_q, last_qx, last_qy);
        end
        cyc();
        n_cmp++;
        if (s_kv !== 1'b0 || s_kx !== 5'd5 || s_ky !== 4'd6) begin
            n_err++; $display("FAIL kill_pulse_hold: got kv=%0d kill=(%0d,%0d) want 0 (5,6)", s_kv, s_kx, s_ky);
        end
        got = 1'b0; h0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!got) begin cyc(); if (s_en) begin got = 1'b1; h0 = s_hit; end end
        end
        cyc(); h1 = s_hit;
        cyc(); h2 = s_hit;
        n_cmp++;
        if ({h0, h1, h2} !== 3'b110 || bullet_flying !== 1'b0) begin
            n_err++; $display("FAIL hit_hold: got %b flying=%0d want 110 flying=0", {h0, h1, h2}, bullet_flying);
        end
        n_cmp++;
        if (s_shots !== 8'd2 || n_kill !== 1) begin
            n_err++; $display("FAIL hit_counts: got shots=%0d kills=%0d want 2/1", s_shots, n_kill);
        end
    endtask

    task automatic test_drop_in_hit();
        logic got;
        n_tick = 0;
        for (int i = 0; i < 80; i++) begin
            if (n_tick < 4) cyc();
        end
        repeat (2) cyc();
        aon = 1'b1; fire_btn = 1'b1; got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!got) begin cyc(); if (i == 6) fire_btn = 1'b0; if (s_kv) got = 1'b1; end
        end
        fire_btn = 1'b0;
        game_run = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (!got || {s_en, s_shoot, s_hit, s_qv, s_qx, s_qy, s_kv} !== 13'd0 || s_shots !== 8'd3) begin
            n_err++; $display("FAIL drop_in_hit: got kill=%0d en=%0d sh=%0d hit=%0d qv=%0d kv=%0d shots=%0d want 1 0 0 0 0 0 3",
                              got, s_en, s_shoot, s_hit, s_qv, s_kv, s_shots);
        end
        n_tick = 0;
        repeat (3 * DIV) cyc();
        n_cmp++;
        if (n_tick !== 0 || s_shots !== 8'd3) begin
            n_err++; $display("FAIL idle_no_ticks: got ticks=%0d shots=%0d want 0/3", n_tick, s_shots);
        end
    endtask

    task automatic test_saturation();
        logic got;
        int to;
        bullet_flying = 1'b0; alien_present = 1'b0; aon = 1'b0; short_flight = 1'b1;
        game_run = 1'b1; to = 0;
        cyc();
        for (int k = 0; k < 257; k++) begin
            got = 1'b0; fire_btn = 1'b1;
            for (int i = 0; i < 12; i++) begin
                if (!got) begin cyc(); if (s_shoot) got = 1'b1; end
            end
            fire_btn = 1'b0;
            if (!got) to++;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (!got) begin cyc(); if (!s_shoot) got = 1'b1; end
            end
            if (!got) to++;
            if (k == 250) begin
                n_cmp++;
                if (s_shots !== 8'd254) begin n_err++; $display("FAIL shots_254: got %0d want 254", s_shots); end
            end
            if (k == 251) begin
                n_cmp++;
                if (s_shots !== 8'd255) begin n_err++; $display("FAIL shots_255: got %0d want 255", s_shots); end
            end
            n_tick = 0;
            for (int i = 0; i < 100; i++) begin
                if (n_tick < 6) cyc();
            end
        end
        n_cmp++;
        if (to !== 0) begin n_err++; $display("FAIL sat_timeouts: got %0d want 0", to); end
        n_cmp++;
        if (s_shots !== 8'd255) begin n_err++; $display("FAIL shots_saturate: got %0d want 255", s_shots); end
    endtask

    task automatic test_reset_mid_flight();
        logic got;
        int n;
        short_flight = 1'b0; posh = 5'd3; fire_btn = 1'b1; got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!got) begin cyc(); if (s_shoot) got = 1'b1; end
        end
        fire_btn = 1'b0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!got) begin cyc(); if (!s_shoot) got = 1'b1; end
        end
        repeat (3) cyc();
        rst_n = 1'b0;
        repeat (3) cyc();
        n_cmp++;
        if ({s_en, s_shoot, s_hit, s_qv, s_qx, s_qy, s_kv, s_kx, s_ky, s_shots} !== 31'd0) begin
            n_err++; $display("FAIL reset_mid_flight: got shots=%0d en=%0d sh=%0d want all 0", s_shots, s_en, s_shoot);
        end
        bullet_flying = 1'b0; bullet_y = 4'd0; alien_present = 1'b0;
        fire_btn = 1'b1; rst_n = 1'b1; game_run = 1'b1; got = 1'b0; n = 0;
        for (int i = 1; i <= 10; i++) begin
            if (!got) begin cyc(); if (s_shoot) begin got = 1'b1; n = i; end end
        end
        fire_btn = 1'b0;
        n_cmp++;
        if (n !== 4) begin n_err++; $display("FAIL reset_to_ready: got %0d cycles to shoot want 4", n); end
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (viol_zero !== 0) begin n_err++; $display("FAIL query_zero_idle: got %0d violations want 0", viol_zero); end
        n_cmp++;
        if (viol_both !== 0) begin n_err++; $display("FAIL shoot_hit_exclusive: got %0d violations want 0", viol_both); end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_miss_top();
        test_cooldown();
        test_hit();
        test_drop_in_hit();
        test_saturation();
        test_reset_mid_flight();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
